// File: rtl/vliw_mem_pkg.sv
// Shared types and defaults for the VLIW memory access unit.
//   ADDR_W_DEF : default memory word-index width (2**ADDR_W words of 32 bits)
//   RD_W_DEF   : default destination register index width
//   state_e    : sequencer states
//   slot_t     : one latched memory-slot request
package vliw_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 22;
  localparam int unsigned RD_W_DEF   = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1
  } state_e;

  // The rd field is sized to the package default, so the top's RD_W must match it.
  typedef struct packed {
    logic                en;
    logic                we;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic [RD_W_DEF-1:0] rd;
  } slot_t;

endpackage

// File: rtl/vliw_mem_addr_chk.sv
// Byte-address check and translation for one memory slot (combinational).
//   addr     : byte address
//   word_idx : word index addr[ADDR_W+1:2]
//   ok       : address is word aligned and inside the 2**ADDR_W-word memory
module vliw_mem_addr_chk
  import vliw_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [31:0]       addr,
  output logic [ADDR_W-1:0] word_idx,
  output logic              ok
);

  assign word_idx = addr[ADDR_W+1:2];
  assign ok       = (addr[1:0] == 2'b00) && (addr[31:ADDR_W+2] == '0);

endmodule

// File: rtl/vliw_mem_access_unit.sv
// Serialises the two memory slots of a VLIW bundle onto a single-port, word-addressed
// data memory, slot 0 first. Load data returns to writeback one cycle after issue;
// misaligned or out-of-range slots are suppressed and flagged.
//   clk, rst                    : clock, asynchronous active-high reset
//   req_valid / req_ready       : bundle handshake from issue
//   sN_en/we/addr/wdata/rd      : slot N request (N = 0, 1)
//   mem_en/we/addr/wdata        : memory request, mem_rdata valid the cycle after a read
//   wb_valid/slot/rd/data       : load writeback
//   err_valid / err_slot        : one-cycle pulse for a suppressed slot
//   busy                        : a bundle is being serviced
module vliw_mem_access_unit
  import vliw_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              s0_en,
  input  logic              s0_we,
  input  logic [31:0]       s0_addr,
  input  logic [31:0]       s0_wdata,
  input  logic [RD_W-1:0]   s0_rd,
  input  logic              s1_en,
  input  logic              s1_we,
  input  logic [31:0]       s1_addr,
  input  logic [31:0]       s1_wdata,
  input  logic [RD_W-1:0]   s1_rd,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic              wb_slot,
  output logic [RD_W-1:0]   wb_rd,
  output logic [31:0]       wb_data,
  output logic              err_valid,
  output logic              err_slot,
  output logic              busy
);

  state_e          state_q;
  slot_t           slot0_q, slot1_q;
  logic            wb_valid_q, wb_slot_q;
  logic [RD_W-1:0] wb_rd_q;

  slot_t             cur;
  logic              cur_is_s1;
  logic              issuing;
  logic [ADDR_W-1:0] cur_idx;
  logic              cur_ok;

  assign cur_is_s1 = (state_q == ACC1);
  assign cur       = cur_is_s1 ? slot1_q : slot0_q;
  // A slot's state is only entered when that slot is enabled; the en terms keep it explicit.
  assign issuing   = ((state_q == ACC0) && slot0_q.en) || ((state_q == ACC1) && slot1_q.en);

  vliw_mem_addr_chk #(
    .ADDR_W (ADDR_W)
  ) u_addr_chk (
    .addr     (cur.addr),
    .word_idx (cur_idx),
    .ok       (cur_ok)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    err_valid = 1'b0;
    err_slot  = 1'b0;
    if (issuing) begin
      if (cur_ok) begin
        mem_en    = 1'b1;
        mem_we    = cur.we;
        mem_addr  = cur_idx;
        mem_wdata = cur.wdata;
      end else begin
        err_valid = 1'b1;
        err_slot  = cur_is_s1;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wb_valid  = wb_valid_q;
  assign wb_slot   = wb_slot_q;
  assign wb_rd     = wb_rd_q;
  // Memory read data passes straight through; zeroed when no writeback is pending.
  assign wb_data   = wb_valid_q ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      slot0_q    <= '0;
      slot1_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_slot_q  <= 1'b0;
      wb_rd_q    <= '0;
    end else begin
      wb_valid_q <= issuing && cur_ok && !cur.we;
      if (issuing && cur_ok && !cur.we) begin
        wb_slot_q <= cur_is_s1;
        wb_rd_q   <= cur.rd;
      end
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            slot0_q <= '{en: s0_en, we: s0_we, addr: s0_addr, wdata: s0_wdata, rd: s0_rd};
            slot1_q <= '{en: s1_en, we: s1_we, addr: s1_addr, wdata: s1_wdata, rd: s1_rd};
            if (s0_en)      state_q <= ACC0;
            else if (s1_en) state_q <= ACC1;
            else            state_q <= IDLE;
          end
        end
        ACC0:    state_q <= slot1_q.en ? ACC1 : IDLE;
        ACC1:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vliw_mem_access_unit.sv
// Self-checking bench for vliw_mem_access_unit: directed cases with literal expectations,
// then randomized bundles checked every cycle against a schedule-based reference model.
module tb_vliw_mem_access_unit;
  import vliw_mem_pkg::*;

  localparam int unsigned AW = 22;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic          s0_en, s0_we, s1_en, s1_we;
  logic [31:0]   s0_addr, s0_wdata, s1_addr, s1_wdata;
  logic [RW-1:0] s0_rd, s1_rd;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          wb_valid, wb_slot;
  logic [RW-1:0] wb_rd;
  logic [31:0]   wb_data;
  logic          err_valid, err_slot, busy;

  vliw_mem_access_unit #(.ADDR_W(AW), .RD_W(RW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .s0_en(s0_en), .s0_we(s0_we), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_rd(s0_rd),
    .s1_en(s1_en), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_rd(s1_rd),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_slot(wb_slot), .wb_rd(wb_rd),
    .wb_data(wb_data), .err_valid(err_valid), .err_slot(err_slot), .busy(busy)
  );

  always #5 clk = ~clk;

  // Initial memory contents, shared by the memory model and the reference model.
  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  // Data memory: in-range bench addresses all fall in words 0..255.
  logic [31:0] env_mem [256];
  bit          env_init;
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
      env_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr[7:0]];
    end
  end

  // Expected outputs for one cycle.
  typedef struct packed {
    logic          ready, busy, men, mwe;
    logic [AW-1:0] maddr;
    logic [31:0]   mwd;
    logic          err, eslot, wbv, wbs;
    logic [RW-1:0] wbrd;
    logic [31:0]   wbd;
  } exp_t;

  exp_t        sched [8];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_saved [256];
  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic slot_t mk(input logic en, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [RW-1:0] rd);
    slot_t s;
    s.en = en; s.we = we; s.addr = addr; s.wdata = wdata; s.rd = rd;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 8; i++) sched[i] = idle_e();
  endtask

  // Reference: a bundle's enabled slots occupy consecutive cycles starting one after
  // acceptance; each load's result appears the cycle after it issues.
  task automatic model_accept(input slot_t a, input slot_t b);
    slot_t         s [2];
    int            j;
    logic [AW-1:0] idx;
    s[0] = a; s[1] = b;
    j = 1;
    for (int n = 0; n < 2; n++) begin
      if (s[n].en) begin
        sched[j].ready = 1'b0;
        sched[j].busy  = 1'b1;
        if (s[n].addr[1:0] == 2'b00 && (s[n].addr >> (AW + 2)) == 0) begin
          idx = s[n].addr[AW+1:2];
          sched[j].men   = 1'b1;
          sched[j].mwe   = s[n].we;
          sched[j].maddr = idx;
          sched[j].mwd   = s[n].wdata;
          if (s[n].we) begin
            ref_mem[idx[7:0]] = s[n].wdata;
          end else begin
            sched[j+1].wbv  = 1'b1;
            sched[j+1].wbs  = n[0];
            sched[j+1].wbrd = s[n].rd;
            sched[j+1].wbd  = ref_mem[idx[7:0]];
          end
        end else begin
          sched[j].err   = 1'b1;
          sched[j].eslot = n[0];
        end
        j++;
      end
    end
  endtask

  // Called at a falling edge: compare this cycle, drive the next inputs, advance a cycle.
  task automatic step(input logic v, input slot_t a, input slot_t b);
    exp_t cur;
    cur = sched[0];
    chk("req_ready", 32'(req_ready), 32'(cur.ready));
    chk("busy", 32'(busy), 32'(cur.busy));
    chk("mem_en", 32'(mem_en), 32'(cur.men));
    chk("err_valid", 32'(err_valid), 32'(cur.err));
    chk("wb_valid", 32'(wb_valid), 32'(cur.wbv));
    if (cur.men) begin
      chk("mem_we", 32'(mem_we), 32'(cur.mwe));
      chk("mem_addr", 32'(mem_addr), 32'(cur.maddr));
      chk("mem_wdata", mem_wdata, cur.mwd);
    end
    if (cur.err) chk("err_slot", 32'(err_slot), 32'(cur.eslot));
    if (cur.wbv) begin
      chk("wb_slot", 32'(wb_slot), 32'(cur.wbs));
      chk("wb_rd", 32'(wb_rd), 32'(cur.wbrd));
      chk("wb_data", wb_data, cur.wbd);
    end
    req_valid = v;
    s0_en = a.en; s0_we = a.we; s0_addr = a.addr; s0_wdata = a.wdata; s0_rd = a.rd;
    s1_en = b.en; s1_we = b.we; s1_addr = b.addr; s1_wdata = b.wdata; s1_rd = b.rd;
    if (v && cur.ready) model_accept(a, b);
    for (int i = 0; i < 7; i++) sched[i] = sched[i+1];
    sched[7] = idle_e();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_slot"}, 32'(wb_slot), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_err_valid"}, 32'(err_valid), 32'd0);
    chk({tag, "_err_slot"}, 32'(err_slot), 32'd0);
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    a = 32'($urandom_range(0, 15)) << 2;
    if (r == 0)      a = a | 32'($urandom_range(1, 3));
    else if (r == 1) a = a | (32'd1 << $urandom_range(AW + 2, 31));
    return a;
  endfunction

  function automatic slot_t rnd_slot();
    return mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
              RW'($urandom_range(0, 31)));
  endfunction

  initial begin
    int nwb;
    rst = 1'b1;
    req_valid = 1'b0;
    s0_en = 0; s0_we = 0; s0_addr = 0; s0_wdata = 0; s0_rd = 0;
    s1_en = 0; s1_we = 0; s1_addr = 0; s1_wdata = 0; s1_rd = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    clear_sched();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    idle(2);

    // Reset in the middle of ACC0 of a two-store bundle: neither store reaches memory.
    ref_saved = ref_mem;
    step(1'b1, mk(1, 1, 32'h190, 32'h1111_1111, 0), mk(1, 1, 32'h194, 32'h2222_2222, 0));
    chk("acc0_mem_en", 32'(mem_en), 32'd1);
    chk("acc0_mem_addr", 32'(mem_addr), 32'd100);
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid_acc0");
    @(negedge clk);
    @(negedge clk);
    chk("no_store_s0", env_mem[100], init_word(100));
    chk("no_store_s1", env_mem[101], init_word(101));
    rst = 1'b0;
    clear_sched();
    ref_mem = ref_saved;
    idle(2);

    // Single load of word 4.
    step(1'b1, mk(1, 0, 32'h10, 32'h0, 5'd7), '0);
    chk("ld_mem_en", 32'(mem_en), 32'd1);
    chk("ld_mem_addr", 32'(mem_addr), 32'd4);
    step(1'b0, '0, '0);
    chk("ld_wb_valid", 32'(wb_valid), 32'd1);
    chk("ld_wb_rd", 32'(wb_rd), 32'd7);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    idle(2);

    // Store then load of the same address in one bundle.
    step(1'b1, mk(1, 1, 32'h20, 32'h1234_5678, 0), mk(1, 0, 32'h20, 32'h0, 5'd3));
    chk("fwd_t1_we", 32'(mem_we), 32'd1);
    chk("fwd_t1_busy", 32'(busy), 32'd1);
    step(1'b0, '0, '0);
    chk("fwd_t2_en", 32'(mem_en), 32'd1);
    chk("fwd_t2_we", 32'(mem_we), 32'd0);
    chk("fwd_t2_busy", 32'(busy), 32'd1);
    step(1'b0, '0, '0);
    chk("fwd_t3_data", wb_data, 32'h1234_5678);
    chk("fwd_t3_busy", 32'(busy), 32'd0);
    idle(2);

    // Misaligned slot 0, out-of-range slot 1.
    step(1'b1, mk(1, 0, 32'h6, 0, 5'd1), mk(1, 0, 32'h0100_0000, 0, 5'd2));
    chk("err_t1_valid", 32'(err_valid), 32'd1);
    chk("err_t1_slot", 32'(err_slot), 32'd0);
    chk("err_t1_mem_en", 32'(mem_en), 32'd0);
    step(1'b0, '0, '0);
    chk("err_t2_valid", 32'(err_valid), 32'd1);
    chk("err_t2_slot", 32'(err_slot), 32'd1);
    chk("err_t2_mem_en", 32'(mem_en), 32'd0);
    step(1'b0, '0, '0);
    chk("err_t3_wb", 32'(wb_valid), 32'd0);
    idle(2);

    // Empty bundle, then a slot-1-only store.
    step(1'b1, '0, '0);
    chk("empty_mem_en", 32'(mem_en), 32'd0);
    chk("empty_ready", 32'(req_ready), 32'd1);
    step(1'b1, '0, mk(1, 1, 32'h40, 32'hCAFE_F00D, 0));
    chk("s1st_mem_en", 32'(mem_en), 32'd1);
    chk("s1st_mem_we", 32'(mem_we), 32'd1);
    chk("s1st_mem_addr", 32'(mem_addr), 32'd16);
    chk("s1st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    idle(2);

    // req_valid held high with two-load bundles: one accept every three cycles.
    nwb = 0;
    for (int k = 0; k < 9; k++) begin
      step(1'b1, mk(1, 0, 32'h8, 0, RW'(2 * k)), mk(1, 0, 32'hC, 0, RW'(2 * k + 1)));
      if (wb_valid) nwb++;
    end
    chk("b2b_wb_pulses", 32'(nwb), 32'd6);
    idle(3);

    // Randomized bundles, checked every cycle against the model.
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 9) < 7), rnd_slot(), rnd_slot());
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/vliw_mem_access_unit.md
# vliw_mem_access_unit

Serialises the two memory-slot operations of a VLIW bundle into the single-port, word-addressed data memory. The block sits between the issue stage and the data memory: it accepts one bundle per handshake, checks and translates byte addresses to word indices, and issues slot 0 before slot 1 (program order). It returns load data to writeback with fixed latency and flags misaligned or out-of-range accesses.

## Interface
- ADDR_W, 22, memory word-index width (memory depth 2**ADDR_W words of 32 bits)
- RD_W, 5, destination register index width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  bundle present from issue
- req_ready  out  1  unit can accept a bundle
- sN_en  in  1  slot N (N=0,1) carries a memory op
- sN_we  in  1  1 = store, 0 = load
- sN_addr  in  32  byte address
- sN_wdata  in  32  store data
- sN_rd  in  RD_W  load destination register
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word index
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after a read issue
- wb_valid  out  1  load result valid
- wb_slot  out  1  slot that produced the result
- wb_rd  out  RD_W  destination register
- wb_data  out  32  load data
- err_valid  out  1  one-cycle pulse: access suppressed
- err_slot  out  1  offending slot
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACC0, ACC1.
- IDLE: req_ready=1. On req_valid: latch both slots. Next state ACC0 if s0_en, else ACC1 if s1_en, else IDLE (empty bundle consumed, no memory activity).
- ACC0: issue slot 0. Next state ACC1 if latched s1_en, else IDLE.
- ACC1: issue slot 1. Next state IDLE.
- req_ready=0 in ACC0/ACC1; req_valid there is ignored and not latched.
- Issue: word index = addr[ADDR_W+1:2]; mem_en=1, mem_we=we, mem_wdata=wdata.
- Address check (per slot, on latched value): misaligned if addr[1:0]!=0; out of range if any bit addr[31:ADDR_W+2] is set.
  - On failure: mem_en=0 that cycle, err_valid=1 and err_slot=N in the same cycle, no writeback. The state still advances.
- Ordering: slot 0 store and slot 1 load to the same address returns the stored value. Two stores to the same address leave the slot 1 value.
- Two loads in one bundle produce two wb_valid pulses on consecutive cycles, slot 0 first.

## Timing
- Accept at edge T. Slot 0 issues in cycle T+1. Slot 1 issues in T+2, or in T+1 if s0_en=0.
- Load latency: wb_valid is registered and asserted the cycle after issue. wb_data = mem_rdata in that cycle (pass-through). wb_rd and wb_slot are registered with wb_valid.
- After the last access, IDLE is re-entered the next cycle. The final load's writeback may coincide with acceptance of the next bundle.
- Throughput: one bundle per 1 cycle (empty), 2 cycles (one slot), or 3 cycles (both slots).
- Reset (asynchronous, at any time):
  - State goes to IDLE and latched slots are cleared.
  - req_ready=1; busy, mem_en, mem_we, wb_valid, err_valid = 0.
  - mem_addr, mem_wdata, wb_rd, wb_slot, wb_data, err_slot = 0.
  - Pending writeback is dropped. A reset during ACC0 issues no slot 1 access.

## Structure
- Package vliw_mem_pkg holds:
  - ADDR_W and RD_W defaults
  - state enum {IDLE, ACC0, ACC1}
  - slot request struct {en, we, addr, wdata, rd}
- Sub-module vliw_mem_addr_chk: combinational; byte address in, word index plus ok flag out. Instantiate once, muxed by the current slot.

## Test plan
- Reset mid-ACC0 after accepting two stores → slot 1 store never issued; all outputs at reset values; req_ready=1.
- Single load, s0 addr 0x0000_0010, mem word 4 = 0xDEADBEEF, rd=7:
  - mem_en=1, mem_addr=4 one cycle after accept.
  - Next cycle: wb_valid=1, wb_rd=7, wb_data=0xDEADBEEF.
- Bundle s0 store 0x0000_0020←0x1234_5678, s1 load 0x0000_0020 → store at cycle T+1, load at T+2, wb_data=0x1234_5678 at T+3, busy high for 2 cycles.
- s0 load addr 0x0000_0006 (misaligned), s1 load addr 0x0100_0000 (out of range, ADDR_W=22):
  - err_valid in two consecutive cycles, err_slot 0 then 1.
  - mem_en=0 throughout; no wb_valid.
- Empty bundle (both en=0) followed by a slot-1-only store → first bundle consumed with no mem_en; store issues one cycle after the second accept with mem_we=1.
- req_valid held high continuously with two-load bundles → accept every 3 cycles; wb pulses alternate slot 0, slot 1 with correct rd values.
